mode_sequencer: RTL

//  Parametrised successor to the top-level mode control FSM. Takes NUM_MODES asynchronous trigger inputs
//  and synchronises them. Each accepted request runs as one mode transaction:

---
 rtl/mode_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mode_sequencer.sv
// mode_sequencer: top-level mode control FSM.
// Each trigger input on req starts one transaction: the command phase, then the work phase,
// then an optional hold phase until that mode's finish input rises, then an idle report.
// CMD and WORK time out into a one-cycle ERR state. Requests that are not accepted are
// counted in a saturating drop counter.
//
// Ports:
//   sys_clk      system clock
//   rst_n        asynchronous reset, active-low
//   i_req        asynchronous mode triggers, rising-edge sensitive
//   i_finish     asynchronous per-mode finish, rising-edge sensitive
//   o_cmd_code   command code to the sender (mode m -> m+1, report -> 0)
//   o_cmd_valid  command request level, held until i_cmd_done
//   i_cmd_done   1-cycle pulse from the sender: frame transmitted
//   o_work_en    work phase enable
//   o_work_mode  one-hot active mode, valid while o_work_en=1
//   i_work_done  1-cycle pulse from the work engine
//   o_busy       1 in every state except IDLE
//   o_err        1-cycle pulse on timeout
//   o_err_mode   one-hot mode that timed out; sticky until the next error or reset
//   o_drop_cnt   saturating count of request edges that were not accepted
//   o_led        {err_seen, work_en, busy}
module mode_sequencer #(
  parameter int unsigned          NUM_MODES   = 3,
  parameter int unsigned          CMD_W       = 2,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [NUM_MODES-1:0] HOLD_MASK   = 3'b100,
  parameter int unsigned          TIMEOUT_CYC = 1000000
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [NUM_MODES-1:0] i_req,
  input  logic [NUM_MODES-1:0] i_finish,
  output logic [CMD_W-1:0]     o_cmd_code,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_done,
  output logic                 o_work_en,
  output logic [NUM_MODES-1:0] o_work_mode,
  input  logic                 i_work_done,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [NUM_MODES-1:0] o_err_mode,
  output logic [7:0]           o_drop_cnt,
  output logic [2:0]           o_led
);

  localparam int unsigned MIDX_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StCmd, StWork, StHold, StReport, StErr} state_e;

  state_e                              r_state;
  logic [SYNC_STAGES-1:0][NUM_MODES-1:0] r_req_sync;
  logic [SYNC_STAGES-1:0][NUM_MODES-1:0] r_fin_sync;
  logic [NUM_MODES-1:0]                r_req_prev;
  logic [NUM_MODES-1:0]                r_fin_prev;
  logic [MIDX_W-1:0]                   r_mode;
  logic [CNT_W-1:0]                    r_tmo_cnt;
  logic [CMD_W-1:0]                    r_cmd_code;
  logic                                r_cmd_valid;
  logic                                r_work_en;
  logic [NUM_MODES-1:0]                r_work_mode;
  logic                                r_busy;
  logic                                r_err;
  logic [NUM_MODES-1:0]                r_err_mode;
  logic                                r_err_seen;
  logic [7:0]                          r_drop_cnt;

  logic [NUM_MODES-1:0] w_req_s;
  logic [NUM_MODES-1:0] w_fin_s;
  logic [NUM_MODES-1:0] w_req_edge;
  logic [NUM_MODES-1:0] w_fin_edge;
  logic                 w_req_any;
  logic [MIDX_W-1:0]    w_req_idx;
  logic [7:0]           w_req_cnt;
  logic [7:0]           w_drop_inc;
  logic [8:0]           w_drop_sum;
  logic [NUM_MODES-1:0] w_mode_onehot;
  logic                 w_tmo;

  assign w_req_s    = r_req_sync[SYNC_STAGES-1];
  assign w_fin_s    = r_fin_sync[SYNC_STAGES-1];
  assign w_req_edge = w_req_s & ~r_req_prev;
  assign w_fin_edge = w_fin_s & ~r_fin_prev;

  assign w_mode_onehot = NUM_MODES'(1) << r_mode;
  assign w_tmo = (TIMEOUT_CYC != 0) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Lowest index wins; every other edge in the same cycle is a drop.
  always_comb begin
    w_req_any = |w_req_edge;
    w_req_idx = '0;
    w_req_cnt = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (w_req_edge[i]) w_req_idx = MIDX_W'(i);
    end
    for (int i = 0; i < NUM_MODES; i++) begin
      w_req_cnt = w_req_cnt + {7'd0, w_req_edge[i]};
    end
    w_drop_inc = ((r_state == StIdle) && w_req_any) ? (w_req_cnt - 8'd1) : w_req_cnt;
    w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, w_drop_inc};
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_sync <= '0;
      r_fin_sync <= '0;
      r_req_prev <= '0;
      r_fin_prev <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], i_req};
      r_fin_sync <= {r_fin_sync[SYNC_STAGES-2:0], i_finish};
      r_req_prev <= w_req_s;
      r_fin_prev <= w_fin_s;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_mode      <= '0;
      r_tmo_cnt   <= '0;
      r_cmd_code  <= '0;
      r_cmd_valid <= 1'b0;
      r_work_en   <= 1'b0;
      r_work_mode <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_err_mode  <= '0;
      r_err_seen  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      r_err      <= 1'b0;
      if (r_state == StCmd || r_state == StWork) r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);

      case (r_state)
        StIdle: begin
          if (w_req_any) begin
            r_mode      <= w_req_idx;
            r_cmd_code  <= CMD_W'(w_req_idx) + CMD_W'(1);
            r_cmd_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= StCmd;
          end
        end
        StCmd: begin
          // The awaited pulse takes precedence over a timeout in the same cycle.
          if (i_cmd_done) begin
            r_cmd_valid <= 1'b0;
            r_work_en   <= 1'b1;
            r_work_mode <= w_mode_onehot;
            r_tmo_cnt   <= '0;
            r_state     <= StWork;
          end else if (w_tmo) begin
            r_err       <= 1'b1;
            r_err_mode  <= w_mode_onehot;
            r_err_seen  <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_state     <= StErr;
          end
        end
        StWork: begin
          if (i_work_done) begin
            r_work_en   <= 1'b0;
            r_work_mode <= '0;
            if (HOLD_MASK[r_mode]) begin
              r_state <= StHold;
            end else begin
              r_cmd_code  <= '0;
              r_cmd_valid <= 1'b1;
              r_state     <= StReport;
            end
          end else if (w_tmo) begin
            r_err       <= 1'b1;
            r_err_mode  <= w_mode_onehot;
            r_err_seen  <= 1'b1;
            r_work_en   <= 1'b0;
            r_work_mode <= '0;
            r_state     <= StErr;
          end
        end
        StHold: begin
          if (w_fin_edge[r_mode]) begin
            r_cmd_code  <= '0;
            r_cmd_valid <= 1'b1;
            r_state     <= StReport;
          end
        end
        StReport: begin
          if (i_cmd_done) begin
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        StErr: begin
          r_cmd_code  <= '0;
          r_cmd_valid <= 1'b1;
          r_state     <= StReport;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cmd_code  = r_cmd_code;
  assign o_cmd_valid = r_cmd_valid;
  assign o_work_en   = r_work_en;
  assign o_work_mode = r_work_mode;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_err_mode  = r_err_mode;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_led       = {r_err_seen, r_work_en, r_busy};

endmodule
